cluster_job_sequencer: RTL and testbench

- Sequences one Compute_Cluster through a convolution job: loads IFM and per-compute-unit filter chunks into the cluster's ping-pong buffers, runs each chunk, then drains the accumulated output buffer.
- Loading of chunk n+1 overlaps computation of chunk n.
- Sits between the host/DMA stream and the cluster. The data buses (sparsemap and nonzero data) go straight to the cluster; this block drives only the valid, count, select and control signals.

---
 rtl/cluster_job_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_cluster_job_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_job_sequencer.sv
// cluster_job_sequencer: steps one compute cluster through a chunked job,
// overlapping ping-pong bank loads with compute, then drains the outputs.
module cluster_job_sequencer #(
    parameter int WR_CYC_NUM  = 4,
    parameter int CU_NUM      = 4,
    parameter int OUT_BUF_NUM = 4,
    parameter int RD_SM_NUM   = 16,
    parameter int CHUNK_W     = 8,
    localparam int WCW = (WR_CYC_NUM > 1) ? $clog2(WR_CYC_NUM) : 1,
    localparam int CUW = (CU_NUM > 1) ? $clog2(CU_NUM) : 1,
    localparam int OBW = (OUT_BUF_NUM > 1) ? $clog2(OUT_BUF_NUM) : 1,
    localparam int SMW = (RD_SM_NUM > 1) ? $clog2(RD_SM_NUM) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [CHUNK_W-1:0] cmd_chunk_num_i,
    input  logic [OBW-1:0]     cmd_acc_buf_i,
    input  logic [SMW-1:0]     cmd_sm_last_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic               ifm_wr_valid_o,
    output logic [WCW-1:0]     ifm_wr_count_o,
    output logic               ifm_wr_sel_o,
    output logic               ifm_rd_sel_o,
    output logic               filter_wr_valid_o,
    output logic [WCW-1:0]     filter_wr_count_o,
    output logic               filter_wr_sel_o,
    output logic               filter_rd_sel_o,
    output logic [OBW-1:0]     filter_wr_order_sel_o,
    output logic               run_valid_o,
    output logic               total_chunk_start_o,
    output logic [SMW-1:0]     rd_sparsemap_last_o,
    input  logic               total_chunk_end_i,
    output logic [OBW-1:0]     acc_buf_sel_o,
    output logic [OBW-1:0]     out_buf_sel_o,
    output logic [CUW-1:0]     com_unit_out_buf_sel_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               job_done_o
);

    typedef enum logic [1:0] {
        L_IDLE,
        L_IFM,
        L_FLT
    } ld_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_START,
        C_RUN,
        C_DRAIN
    } cp_state_t;

    localparam logic [WCW-1:0]     BEAT_LAST = WCW'(WR_CYC_NUM - 1);
    localparam logic [CUW-1:0]     CU_LAST   = CUW'(CU_NUM - 1);
    localparam logic [CHUNK_W-1:0] CH_ONE    = CHUNK_W'(1);

    ld_state_t          ld_q, ld_d;
    cp_state_t          cp_q, cp_d;
    logic               job_q, job_d;
    logic               done_q, done_d;
    logic [CHUNK_W-1:0] num_q, num_d;
    logic [OBW-1:0]     acc_q, acc_d;
    logic [SMW-1:0]     sm_q, sm_d;
    logic [WCW-1:0]     beat_q, beat_d;
    logic [CUW-1:0]     cu_q, cu_d;
    logic [CUW-1:0]     drain_q, drain_d;
    logic [CHUNK_W-1:0] loaded_q, loaded_d;
    logic [CHUNK_W-1:0] cdone_q, cdone_d;
    logic               wp_q, wp_d;
    logic               rp_q, rp_d;
    logic [1:0]         full_q, full_d;

    logic accept;
    logic beat;
    logic set_full;
    logic clr_full;
    logic job_end;
    logic last_chunk;

    assign cmd_ready_o = ~job_q & ~rst_i;
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign in_ready_o  = (ld_q == L_IFM) || (ld_q == L_FLT);
    assign beat        = in_valid_i & in_ready_o;
    assign last_chunk  = (cdone_q + CH_ONE) == num_q;

    // Loader: one IFM chunk, then one filter chunk per compute unit.
    always_comb begin
        ld_d     = ld_q;
        beat_d   = beat_q;
        cu_d     = cu_q;
        loaded_d = loaded_q;
        wp_d     = wp_q;
        set_full = 1'b0;
        unique case (ld_q)
            L_IDLE: begin
                if (job_q && (loaded_q < num_q) && !full_q[wp_q]) begin
                    ld_d   = L_IFM;
                    beat_d = '0;
                end
            end
            L_IFM: begin
                if (beat) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d = '0;
                        cu_d   = '0;
                        ld_d   = L_FLT;
                    end else begin
                        beat_d = beat_q + WCW'(1);
                    end
                end
            end
            L_FLT: begin
                if (beat) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d = '0;
                        if (cu_q == CU_LAST) begin
                            set_full = 1'b1;
                            wp_d     = ~wp_q;
                            loaded_d = loaded_q + CH_ONE;
                            cu_d     = '0;
                            ld_d     = L_IDLE;
                        end else begin
                            cu_d = cu_q + CUW'(1);
                        end
                    end else begin
                        beat_d = beat_q + WCW'(1);
                    end
                end
            end
            default: ld_d = L_IDLE;
        endcase
        if (accept) begin
            loaded_d = '0;
            wp_d     = 1'b0;
        end
    end

    // Compute: start/run each loaded bank, drain after the final chunk.
    always_comb begin
        cp_d     = cp_q;
        cdone_d  = cdone_q;
        drain_d  = drain_q;
        rp_d     = rp_q;
        clr_full = 1'b0;
        job_end  = 1'b0;
        unique case (cp_q)
            C_IDLE: begin
                if (job_q && full_q[rp_q]) begin
                    cp_d = C_START;
                end
            end
            C_START: cp_d = C_RUN;
            C_RUN: begin
                if (total_chunk_end_i) begin
                    clr_full = 1'b1;
                    rp_d     = ~rp_q;
                    cdone_d  = cdone_q + CH_ONE;
                    drain_d  = '0;
                    cp_d     = last_chunk ? C_DRAIN : C_IDLE;
                end
            end
            C_DRAIN: begin
                if (out_ready_i) begin
                    if (drain_q == CU_LAST) begin
                        job_end = 1'b1;
                        drain_d = '0;
                        cp_d    = C_IDLE;
                    end else begin
                        drain_d = drain_q + CUW'(1);
                    end
                end
            end
            default: cp_d = C_IDLE;
        endcase
        if (accept) begin
            cdone_d = '0;
            rp_d    = 1'b0;
        end
    end

    always_comb begin
        job_d  = job_q;
        done_d = job_end;
        num_d  = num_q;
        acc_d  = acc_q;
        sm_d   = sm_q;
        full_d = full_q;
        if (set_full) begin
            full_d[wp_q] = 1'b1;
        end
        if (clr_full) begin
            full_d[rp_q] = 1'b0;
        end
        if (job_end) begin
            job_d = 1'b0;
        end
        if (accept) begin
            num_d = cmd_chunk_num_i;
            acc_d = cmd_acc_buf_i;
            sm_d  = cmd_sm_last_i;
            if (cmd_chunk_num_i == '0) begin
                done_d = 1'b1;
            end else begin
                job_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_q     <= L_IDLE;
            cp_q     <= C_IDLE;
            job_q    <= 1'b0;
            done_q   <= 1'b0;
            num_q    <= '0;
            acc_q    <= '0;
            sm_q     <= '0;
            beat_q   <= '0;
            cu_q     <= '0;
            drain_q  <= '0;
            loaded_q <= '0;
            cdone_q  <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            full_q   <= '0;
        end else begin
            ld_q     <= ld_d;
            cp_q     <= cp_d;
            job_q    <= job_d;
            done_q   <= done_d;
            num_q    <= num_d;
            acc_q    <= acc_d;
            sm_q     <= sm_d;
            beat_q   <= beat_d;
            cu_q     <= cu_d;
            drain_q  <= drain_d;
            loaded_q <= loaded_d;
            cdone_q  <= cdone_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            full_q   <= full_d;
        end
    end

    assign ifm_wr_valid_o    = (ld_q == L_IFM) & in_valid_i;
    assign ifm_wr_count_o    = (ld_q == L_IFM) ? beat_q : '0;
    assign filter_wr_valid_o = (ld_q == L_FLT) & in_valid_i;
    assign filter_wr_count_o = (ld_q == L_FLT) ? beat_q : '0;
    assign filter_wr_order_sel_o = (ld_q == L_FLT) ? OBW'(cu_q) : '0;
    assign ifm_wr_sel_o      = wp_q;
    assign filter_wr_sel_o   = wp_q;
    assign ifm_rd_sel_o      = rp_q;
    assign filter_rd_sel_o   = rp_q;

    assign run_valid_o         = (cp_q == C_START) || (cp_q == C_RUN);
    assign total_chunk_start_o = (cp_q == C_START);
    assign rd_sparsemap_last_o = sm_q;
    assign acc_buf_sel_o       = acc_q;
    assign out_buf_sel_o       = acc_q;
    assign out_valid_o         = (cp_q == C_DRAIN);
    assign com_unit_out_buf_sel_o = (cp_q == C_DRAIN) ? drain_q : '0;
    assign job_done_o          = done_q;

endmodule

// File: tb/tb_cluster_job_sequencer.sv
// tb_cluster_job_sequencer: randomized jobs checked every cycle against a
// chunk/beat-index model of the sequencer, plus directed scenario checks.
module tb_cluster_job_sequencer;

    localparam int WR  = 4;
    localparam int CU  = 4;
    localparam int CHB = (1 + CU) * WR;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] cmd_chunk_num_i;
    logic [1:0] cmd_acc_buf_i;
    logic [3:0] cmd_sm_last_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic       ifm_wr_valid_o;
    logic [1:0] ifm_wr_count_o;
    logic       ifm_wr_sel_o;
    logic       ifm_rd_sel_o;
    logic       filter_wr_valid_o;
    logic [1:0] filter_wr_count_o;
    logic       filter_wr_sel_o;
    logic       filter_rd_sel_o;
    logic [1:0] filter_wr_order_sel_o;
    logic       run_valid_o;
    logic       total_chunk_start_o;
    logic [3:0] rd_sparsemap_last_o;
    logic       total_chunk_end_i;
    logic [1:0] acc_buf_sel_o;
    logic [1:0] out_buf_sel_o;
    logic [1:0] com_unit_out_buf_sel_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       job_done_o;

    always #5 clk = ~clk;

    cluster_job_sequencer dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .cmd_valid_i           (cmd_valid_i),
        .cmd_ready_o           (cmd_ready_o),
        .cmd_chunk_num_i       (cmd_chunk_num_i),
        .cmd_acc_buf_i         (cmd_acc_buf_i),
        .cmd_sm_last_i         (cmd_sm_last_i),
        .in_valid_i            (in_valid_i),
        .in_ready_o            (in_ready_o),
        .ifm_wr_valid_o        (ifm_wr_valid_o),
        .ifm_wr_count_o        (ifm_wr_count_o),
        .ifm_wr_sel_o          (ifm_wr_sel_o),
        .ifm_rd_sel_o          (ifm_rd_sel_o),
        .filter_wr_valid_o     (filter_wr_valid_o),
        .filter_wr_count_o     (filter_wr_count_o),
        .filter_wr_sel_o       (filter_wr_sel_o),
        .filter_rd_sel_o       (filter_rd_sel_o),
        .filter_wr_order_sel_o (filter_wr_order_sel_o),
        .run_valid_o           (run_valid_o),
        .total_chunk_start_o   (total_chunk_start_o),
        .rd_sparsemap_last_o   (rd_sparsemap_last_o),
        .total_chunk_end_i     (total_chunk_end_i),
        .acc_buf_sel_o         (acc_buf_sel_o),
        .out_buf_sel_o         (out_buf_sel_o),
        .com_unit_out_buf_sel_o(com_unit_out_buf_sel_o),
        .out_valid_o           (out_valid_o),
        .out_ready_i           (out_ready_i),
        .job_done_o            (job_done_o)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // model: job bookkeeping, flat beat index within a chunk, compute phase
    int m_job, m_num, m_acc, m_sm, m_loaded, m_cdone;
    int m_wp, m_rp, m_idx, m_cph, m_drain, m_donep;
    int m_full[2];
    bit armed = 0;
    bit rst_seen = 0;

    int in_mode, out_mode, end_stuck, end_delay, run_cnt;

    int cyc = 0;
    int ifm_log[$], ifm_cyc[$], flt_log[$], flt_cyc[$];
    int rdsel_log[$], end_cyc[$], dsel_log[$], dbuf_log[$];
    int starts, done_cnt, run_cyc, ov_cyc, acc_cnt, start_cyc;

    task automatic chk(string nm, bit ok, int act, int exp);
        n_tot++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [27:0] cur_act();
        return {cmd_ready_o, in_ready_o, ifm_wr_valid_o, ifm_wr_count_o,
                ifm_wr_sel_o, ifm_rd_sel_o, filter_wr_valid_o,
                filter_wr_count_o, filter_wr_sel_o, filter_rd_sel_o,
                filter_wr_order_sel_o, run_valid_o, total_chunk_start_o,
                rd_sparsemap_last_o, acc_buf_sel_o, out_buf_sel_o,
                com_unit_out_buf_sel_o, out_valid_o, job_done_o};
    endfunction

    function automatic logic [27:0] model_exp();
        logic       ld, ifm, flt, e_rdy;
        logic [1:0] e_ic, e_fc, e_cu, e_ds, e_acc;
        logic [3:0] e_sm;
        int         fi;
        ld    = (m_idx >= 0);
        ifm   = ld && (m_idx < WR);
        flt   = ld && (m_idx >= WR);
        fi    = m_idx - WR;
        e_ic  = ifm ? 2'(m_idx % WR) : 2'd0;
        e_fc  = flt ? 2'(fi % WR) : 2'd0;
        e_cu  = flt ? 2'(fi / WR) : 2'd0;
        e_ds  = (m_cph == 3) ? 2'(m_drain) : 2'd0;
        e_acc = 2'(m_acc);
        e_sm  = 4'(m_sm);
        e_rdy = (m_job == 0) && !rst_i;
        return {e_rdy, ld, ifm && in_valid_i, e_ic, 1'(m_wp), 1'(m_rp),
                flt && in_valid_i, e_fc, 1'(m_wp), 1'(m_rp), e_cu,
                (m_cph == 1) || (m_cph == 2), m_cph == 1, e_sm, e_acc,
                e_acc, e_ds, m_cph == 3, m_donep != 0};
    endfunction

    task automatic observe();
        logic [27:0] a, e;
        a = cur_act();
        e = model_exp();
        if (armed && (!rst_i || rst_seen))
            chk("cycle_outputs", a == e, int'(a), int'(e));
        if (ifm_wr_valid_o) begin
            ifm_log.push_back(int'(ifm_wr_count_o));
            ifm_cyc.push_back(cyc);
        end
        if (filter_wr_valid_o) begin
            flt_log.push_back(int'({filter_wr_order_sel_o, filter_wr_count_o}));
            flt_cyc.push_back(cyc);
        end
        if (total_chunk_start_o) begin
            starts++;
            start_cyc = cyc;
            rdsel_log.push_back(int'(ifm_rd_sel_o));
        end
        if (run_valid_o && !total_chunk_start_o && total_chunk_end_i)
            end_cyc.push_back(cyc);
        if (run_valid_o) run_cyc++;
        if (out_valid_o) begin
            ov_cyc++;
            dbuf_log.push_back(int'(out_buf_sel_o));
            if (out_ready_i) begin
                acc_cnt++;
                dsel_log.push_back(int'(com_unit_out_buf_sel_o));
            end
        end
        if (job_done_o) done_cnt++;
    endtask

    task automatic model_step();
        bit accept, setb, clrb, jend;
        int n_idx, n_cph;
        rst_seen = rst_i;
        if (rst_i) begin
            armed = 1;
            m_job = 0; m_num = 0; m_acc = 0; m_sm = 0;
            m_loaded = 0; m_cdone = 0; m_wp = 0; m_rp = 0;
            m_full[0] = 0; m_full[1] = 0;
            m_idx = -1; m_cph = 0; m_drain = 0; m_donep = 0;
        end else begin
            accept = cmd_valid_i && (m_job == 0);
            setb = 0; clrb = 0; jend = 0;
            n_idx = m_idx; n_cph = m_cph;
            if (m_idx < 0) begin
                if (m_job != 0 && m_loaded < m_num && m_full[m_wp] == 0)
                    n_idx = 0;
            end else if (in_valid_i) begin
                if (m_idx == CHB - 1) begin
                    n_idx = -1;
                    setb = 1;
                end else n_idx = m_idx + 1;
            end
            case (m_cph)
                0: if (m_job != 0 && m_full[m_rp] != 0) n_cph = 1;
                1: n_cph = 2;
                2: if (total_chunk_end_i) begin
                    clrb = 1;
                    n_cph = (m_cdone + 1 == m_num) ? 3 : 0;
                    m_drain = 0;
                end
                default: if (out_ready_i) begin
                    if (m_drain == CU - 1) begin
                        jend = 1; n_cph = 0; m_drain = 0;
                    end else m_drain++;
                end
            endcase
            if (clrb) begin
                m_full[m_rp] = 0; m_rp ^= 1; m_cdone++;
            end
            if (setb) begin
                m_full[m_wp] = 1; m_wp ^= 1; m_loaded++;
            end
            m_idx = n_idx;
            m_cph = n_cph;
            m_donep = jend;
            if (jend) m_job = 0;
            if (accept) begin
                m_num = int'(cmd_chunk_num_i);
                m_acc = int'(cmd_acc_buf_i);
                m_sm = int'(cmd_sm_last_i);
                m_loaded = 0; m_cdone = 0; m_wp = 0; m_rp = 0;
                if (m_num == 0) m_donep = 1;
                else m_job = 1;
            end
        end
    endtask

    task automatic drive();
        case (in_mode)
            0: in_valid_i = 1'b0;
            1: in_valid_i = 1'b1;
            default: in_valid_i = ($urandom_range(0, 9) < 7);
        endcase
        case (out_mode)
            0: out_ready_i = 1'b1;
            1: out_ready_i = ~out_ready_i;
            default: out_ready_i = 1'($urandom_range(0, 1));
        endcase
        if (end_stuck != 0) total_chunk_end_i = 1'b1;
        else if (m_cph == 2) begin
            run_cnt++;
            total_chunk_end_i = (run_cnt > end_delay);
        end else begin
            run_cnt = 0;
            total_chunk_end_i = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        observe();
        @(posedge clk);
        model_step();
        #1;
        drive();
    endtask

    task automatic clr_logs();
        ifm_log.delete(); ifm_cyc.delete(); flt_log.delete(); flt_cyc.delete();
        rdsel_log.delete(); end_cyc.delete(); dsel_log.delete(); dbuf_log.delete();
        starts = 0; done_cnt = 0; run_cyc = 0; ov_cyc = 0; acc_cnt = 0;
        start_cyc = 0;
    endtask

    task automatic send_cmd(int num, int acc, int sm);
        chk("cmd_ready_idle", cmd_ready_o == 1'b1, int'(cmd_ready_o), 1);
        cmd_valid_i = 1'b1;
        cmd_chunk_num_i = 8'(num);
        cmd_acc_buf_i = 2'(acc);
        cmd_sm_last_i = 4'(sm);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(int limit);
        int b, n;
        b = done_cnt;
        n = 0;
        while (done_cnt == b && n < limit) begin
            tick();
            n++;
        end
        chk("job_done_timeout", done_cnt != b, n, limit);
        tick();
    endtask

    initial begin
        int err, n, ec0;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_chunk_num_i = '0;
        cmd_acc_buf_i = '0; cmd_sm_last_i = '0; in_valid_i = 1'b0;
        out_ready_i = 1'b0; total_chunk_end_i = 1'b0;
        in_mode = 0; out_mode = 0; end_stuck = 0; end_delay = 5; run_cnt = 0;
        clr_logs();
        repeat (3) tick();
        chk("reset_outputs", cur_act() == '0, int'(cur_act()), 0);
        rst_i = 1'b0;
        #1;
        chk("idle_cmd_ready", cmd_ready_o == 1'b1, int'(cmd_ready_o), 1);

        // reset after six beats of a load abandons the job
        clr_logs();
        in_mode = 1;
        send_cmd(1, 2, 5);
        n = 0;
        while (ifm_log.size() + flt_log.size() < 6 && n < 100) begin
            tick();
            n++;
        end
        chk("midload_beats", ifm_log.size() + flt_log.size() == 6,
            ifm_log.size() + flt_log.size(), 6);
        rst_i = 1'b1;
        tick();
        tick();
        chk("midrst_in_ready", in_ready_o == 1'b0, int'(in_ready_o), 0);
        chk("midrst_outputs", cur_act() == '0, int'(cur_act()), 0);
        rst_i = 1'b0;
        tick();
        chk("midrst_no_done", done_cnt == 0, done_cnt, 0);
        clr_logs();
        send_cmd(1, 1, 3);
        wait_done(500);
        chk("restart_ifm_count0", ifm_log.size() > 0 && ifm_log[0] == 0,
            ifm_log.size() > 0 ? ifm_log[0] : -1, 0);

        // single chunk, acc buffer 2, end ten cycles into the run
        clr_logs();
        in_mode = 1; out_mode = 0; end_delay = 10;
        send_cmd(1, 2, 7);
        chk("sm_last_latched", rd_sparsemap_last_o == 4'd7,
            int'(rd_sparsemap_last_o), 7);
        wait_done(500);
        err = 0;
        foreach (ifm_log[i]) if (ifm_log[i] != i) err++;
        chk("ifm_seq", err == 0 && ifm_log.size() == 4, ifm_log.size(), 4);
        err = 0;
        foreach (flt_log[i]) if (flt_log[i] != ((i / 4) << 2 | (i % 4))) err++;
        chk("flt_seq", err == 0 && flt_log.size() == 16, flt_log.size(), 16);
        chk("start_pulses", starts == 1, starts, 1);
        chk("start_latency", flt_cyc.size() == 16 && start_cyc - flt_cyc[15] == 2,
            flt_cyc.size() == 16 ? start_cyc - flt_cyc[15] : -1, 2);
        err = 0;
        foreach (dsel_log[i]) if (dsel_log[i] != i) err++;
        chk("drain_sel_seq", err == 0 && dsel_log.size() == 4, dsel_log.size(), 4);
        err = 0;
        foreach (dbuf_log[i]) if (dbuf_log[i] != 2) err++;
        chk("drain_out_buf", err == 0, err, 0);
        chk("done_once", done_cnt == 1, done_cnt, 1);

        // three chunks with a slow end: second load overlaps, third stalls
        clr_logs();
        end_delay = 50;
        send_cmd(3, 1, 9);
        wait_done(3000);
        err = 0;
        foreach (rdsel_log[i]) if (rdsel_log[i] != (i % 2)) err++;
        chk("rd_sel_seq", err == 0 && rdsel_log.size() == 3, rdsel_log.size(), 3);
        ec0 = end_cyc.size() > 0 ? end_cyc[0] : 0;
        chk("chunk1_loaded_early", flt_cyc.size() == 48 && flt_cyc[31] < ec0,
            flt_cyc.size() == 48 ? flt_cyc[31] : -1, ec0);
        chk("chunk2_load_waits", ifm_cyc.size() == 12 && ifm_cyc[8] > ec0,
            ifm_cyc.size() == 12 ? ifm_cyc[8] : -1, ec0 + 1);

        // end stuck high: each chunk runs exactly two cycles
        clr_logs();
        end_stuck = 1;
        send_cmd(2, 3, 1);
        wait_done(1000);
        chk("stuck_starts", starts == 2, starts, 2);
        chk("stuck_run_cycles", run_cyc == 4, run_cyc, 4);
        end_stuck = 0;
        tick();

        // zero-chunk job
        clr_logs();
        send_cmd(0, 3, 2);
        tick();
        chk("zero_done_next", done_cnt == 1, done_cnt, 1);
        chk("zero_no_activity", ifm_log.size() + flt_log.size() + run_cyc == 0,
            ifm_log.size() + flt_log.size() + run_cyc, 0);
        repeat (3) tick();
        chk("zero_done_single", done_cnt == 1, done_cnt, 1);

        // out_ready toggling during drain
        clr_logs();
        out_mode = 1; end_delay = 3;
        send_cmd(1, 0, 4);
        wait_done(500);
        chk("toggle_accepts", acc_cnt == 4, acc_cnt, 4);
        chk("toggle_drain_len", ov_cyc >= 7 && ov_cyc <= 8, ov_cyc, 8);

        // randomized jobs, checked cycle by cycle against the model
        for (int j = 0; j < 12; j++) begin
            in_mode = 2;
            out_mode = 2;
            end_stuck = ($urandom_range(0, 4) == 0) ? 1 : 0;
            end_delay = int'($urandom_range(0, 15));
            send_cmd(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 15)));
            wait_done(4000);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
